// File: rtl/ahb_lite_mem_ws.sv
// ahb_lite_mem_ws: AHB-Lite slave memory with configurable depth, wait states, byte-lane writes and two-cycle ERROR responses
//   HCLK, HRESETn                                      : bus clock, asynchronous active-low reset
//   HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE : slave-side bus inputs (HBURST ignored)
//   HRDATA, HREADY, HRESP                              : registered read data, bus ready, OKAY/ERROR response
module ahb_lite_mem_ws #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic pend_wr;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [3:0] wr_strb;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0] strb;
  logic [31:0] rd_word;
  logic accept, bad, commit;
  logic unused;
  assign unused = ^{HBURST, HTRANS[0]};
  assign idx = HADDR[ADDR_WIDTH+1:2];
  assign accept = HREADY && HSEL && HTRANS[1];
  assign bad = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
               32'(idx) >= DEPTH || HADDR[31:ADDR_WIDTH+2] != '0;
  assign strb = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign HREADY = state == IDLE || state == ERR2;
  assign HRESP = state == ERR1 || state == ERR2;
  // A pending write lands on the edge that ends its data phase, which is also the next accept edge
  assign commit = pend_wr && HREADY;
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt = cnt;
    if (state == WAIT) begin
      state_nxt = cnt == 4'd1 ? IDLE : WAIT;
      cnt_nxt = cnt - 4'd1;
    end else if (state == ERR1) state_nxt = ERR2;
    else if (accept) begin
      state_nxt = bad ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
      cnt_nxt = bad ? 4'd0 : 4'(WAIT_STATES);
    end
  end
  // Bytes committed on this same edge are forwarded so write-then-read of a word sees new data
  always_comb begin
    rd_word = mem[idx];
    for (int b = 0; b < 4; b++)
      if (commit && wr_idx == idx && wr_strb[b]) rd_word[8*b+:8] = HWDATA[8*b+:8];
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      cnt <= '0;
      pend_wr <= 1'b0;
      wr_idx <= '0;
      wr_strb <= '0;
      HRDATA <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pend_wr <= accept ? !bad && HWRITE : pend_wr && !HREADY;
      if (accept) begin
        wr_idx <= idx;
        wr_strb <= strb;
      end
      if (accept && !bad && !HWRITE) HRDATA <= rd_word;
    end
  always_ff @(posedge HCLK)
    if (commit)
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) mem[wr_idx][8*b+:8] <= HWDATA[8*b+:8];
endmodule

// File: tb/tb_ahb_lite_mem_ws.sv
// tb_ahb_lite_mem_ws: self-checking bench for ahb_lite_mem_ws at three wait-state settings
module tb_ahb_lite_mem_ws;
  typedef struct {
    int dut;
    logic wr;
    logic [2:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic err;
    logic chk;
    logic [31:0] rdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [2:0] hburst = '0;
  logic [2:0] hsize = '0;
  logic [2:0] sel = '0;
  logic [1:0] htrans = '0;
  logic hwrite = 1'b0;
  logic [31:0] rdata [3];
  logic ready [3];
  logic resp [3];
  int n_chk = 0;
  int n_fail = 0;
  int ws [3] = '{0, 2, 3};
  int dep [3] = '{48, 1024, 1024};
  logic [31:0] mm [3][1024];
  txn_t tq [$];
  txn_t vec [$];
  always #5 clk = ~clk;
  ahb_lite_mem_ws #(.ADDR_WIDTH(6), .DEPTH(48), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HSEL(sel[0]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite), .HRDATA(rdata[0]), .HREADY(ready[0]), .HRESP(resp[0]));
  ahb_lite_mem_ws #(.ADDR_WIDTH(10), .DEPTH(1024), .WAIT_STATES(2)) u1 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HSEL(sel[1]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite), .HRDATA(rdata[1]), .HREADY(ready[1]), .HRESP(resp[1]));
  ahb_lite_mem_ws #(.ADDR_WIDTH(10), .DEPTH(1024), .WAIT_STATES(3)) u2 (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HBURST(hburst), .HSEL(sel[2]), .HSIZE(hsize),
    .HTRANS(htrans), .HWDATA(hwdata), .HWRITE(hwrite), .HRDATA(rdata[2]), .HREADY(ready[2]), .HRESP(resp[2]));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic txn_t mk(input int dut, input logic wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic chk, input logic [31:0] rd);
    txn_t t;
    t.dut = dut;
    t.wr = wr;
    t.size = size;
    t.addr = addr;
    t.wdata = wdata;
    t.err = err;
    t.chk = chk;
    t.rdata = rd;
    return t;
  endfunction
  // Transfers take effect in program order; legality and byte lanes follow from size and alignment arithmetic
  function automatic txn_t model(input int k, input txn_t t);
    int unsigned nb, base, w;
    nb = 1 << t.size;
    base = t.addr % 4;
    w = t.addr / 4;
    t.dut = k;
    t.err = t.size > 2 || t.addr % nb != 0 || w >= 32'(dep[k]);
    t.chk = !t.err && !t.wr;
    t.rdata = '0;
    if (t.chk) t.rdata = mm[k][w];
    if (!t.err && t.wr)
      for (int b = 0; b < 4; b++)
        if (b >= base && b < base + nb) mm[k][w][8*b+:8] = t.wdata[8*b+:8];
    return t;
  endfunction
  // Pipelined master: drives queued address phases, holds them while HREADY=0, and checks each data phase
  task automatic run(input int k);
    txn_t dp;
    bit dpv = 0;
    int i = 0;
    int waits = 0;
    int cyc = 0;
    while (i < tq.size() || dpv) begin
      sel = '0;
      if (i < tq.size()) begin
        sel[k] = 1'b1;
        htrans = 2'b10;
        haddr = tq[i].addr;
        hsize = tq[i].size;
        hwrite = tq[i].wr;
      end else htrans = 2'b00;
      hwdata = dpv && dp.wr ? dp.wdata : 32'h0;
      if (!dpv) check("idle_ready", 32'(ready[k]), 32'd1);
      else if (!ready[k]) begin
        waits++;
        check("wait_resp", 32'(resp[k]), 32'(dp.err));
      end else begin
        check("wait_count", 32'(waits), dp.err ? 32'd1 : 32'(ws[k]));
        check("resp", 32'(resp[k]), 32'(dp.err));
        if (dp.chk) check("rdata", rdata[k], dp.rdata);
        dpv = 0;
      end
      if (ready[k] && i < tq.size()) begin
        dp = tq[i];
        i++;
        dpv = 1;
        waits = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 40 * tq.size() + 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: dut %0d stuck after %0d cycles, required completion", k, cyc);
        break;
      end
    end
    sel = '0;
    htrans = 2'b00;
    tq.delete();
  endtask
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tq.push_back(vec[i]);
      if (i == hi || vec[i+1].dut != vec[i].dut) run(vec[i].dut);
    end
  endtask
  task automatic rand_test(input int k);
    txn_t t;
    int r;
    for (int w = 0; w < 16; w++) tq.push_back(model(k, mk(k, 1'b1, 3'd2, 32'h80 + 32'(4 * w), $urandom, 1'b0, 1'b0, 32'h0)));
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(15);
      t.wr = 1'($urandom_range(1));
      t.size = r < 5 ? 3'd0 : r < 10 ? 3'd1 : r < 14 ? 3'd2 : 3'd3;
      t.addr = $urandom_range(15) == 0 ? 32'(4 * dep[k]) : 32'h80 + 32'($urandom_range(63));
      t.wdata = $urandom;
      tq.push_back(model(k, t));
    end
    run(k);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec.push_back(mk(0, 1, 2, 32'h0,    32'h11223344, 0, 0, 32'h0));
    vec.push_back(mk(0, 1, 2, 32'h4,    32'hAABBCCDD, 0, 0, 32'h0));
    vec.push_back(mk(0, 0, 2, 32'h4,    32'h0,        0, 1, 32'hAABBCCDD));
    vec.push_back(mk(0, 0, 2, 32'h0,    32'h0,        0, 1, 32'h11223344));
    vec.push_back(mk(0, 1, 2, 32'h8,    32'hFFFFFFFF, 0, 0, 32'h0));
    vec.push_back(mk(0, 1, 0, 32'h9,    32'h00005A00, 0, 0, 32'h0));
    vec.push_back(mk(0, 1, 1, 32'hA,    32'h12340000, 0, 0, 32'h0));
    vec.push_back(mk(0, 0, 2, 32'h8,    32'h0,        0, 1, 32'h12345AFF));
    vec.push_back(mk(0, 0, 2, 32'h2,    32'h0,        1, 0, 32'h0));
    vec.push_back(mk(0, 1, 1, 32'h5,    32'h77777777, 1, 0, 32'h0));
    vec.push_back(mk(0, 0, 2, 32'h4,    32'h0,        0, 1, 32'hAABBCCDD));
    vec.push_back(mk(0, 0, 3, 32'h0,    32'h0,        1, 0, 32'h0));
    vec.push_back(mk(0, 0, 2, 32'hC0,   32'h0,        1, 0, 32'h0));
    vec.push_back(mk(0, 1, 2, 32'h1000, 32'hDEADBEEF, 1, 0, 32'h0));
    vec.push_back(mk(0, 0, 2, 32'h0,    32'h0,        0, 1, 32'h11223344));
    vec.push_back(mk(1, 1, 2, 32'h10,   32'hCAFEF00D, 0, 0, 32'h0));
    vec.push_back(mk(1, 0, 2, 32'h10,   32'h0,        0, 1, 32'hCAFEF00D));
    vec.push_back(mk(2, 1, 2, 32'h20,   32'h01020304, 0, 0, 32'h0));
    vec.push_back(mk(2, 0, 2, 32'h20,   32'h0,        0, 1, 32'h01020304));
    vec.push_back(mk(0, 0, 2, 32'h0,    32'h0,        0, 1, 32'h11223344));
    vec.push_back(mk(2, 0, 2, 32'h20,   32'h0,        0, 1, 32'h01020304));
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd1);
      check("rst_resp", 32'(resp[k]), 32'd0);
      check("rst_rdata", rdata[k], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(0, 18);
    // Unselected NONSEQ and selected BUSY must both be ignored
    sel = 3'b000;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize = 3'd2;
    haddr = 32'h0;
    @(posedge clk);
    #1;
    hwdata = 32'h0BAD0BAD;
    check("unsel_ready", 32'(ready[0]), 32'd1);
    sel = 3'b001;
    htrans = 2'b01;
    @(posedge clk);
    #1;
    check("busy_ready", 32'(ready[0]), 32'd1);
    check("busy_resp", 32'(resp[0]), 32'd0);
    sel = 3'b000;
    htrans = 2'b00;
    @(posedge clk);
    #1;
    check("after_busy_ready", 32'(ready[0]), 32'd1);
    apply(19, 19);
    // Reset in the second wait cycle of a write abandons it
    check("pre_rst_rdata", rdata[2], 32'h01020304);
    sel = 3'b100;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize = 3'd2;
    haddr = 32'h20;
    @(posedge clk);
    #1;
    sel = 3'b000;
    htrans = 2'b00;
    hwdata = 32'hDEADBEEF;
    check("ws3_wait1", 32'(ready[2]), 32'd0);
    @(posedge clk);
    #1;
    check("ws3_wait2", 32'(ready[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready[2]), 32'd1);
    check("midrst_resp", 32'(resp[2]), 32'd0);
    check("midrst_rdata", rdata[2], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(20, 20);
    for (int k = 0; k < 3; k++) rand_test(k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
